// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch unit.
//   FETCH_XLEN     default address/PC width
//   fetch_state_e  fetch FSM states (IDLE / WAIT / DROP)
//   fetch_entry_t  instruction queue entry {instr, pc, fault} at default XLEN
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // free to issue a request
    ST_WAIT = 2'd1,  // one request granted, response pending
    ST_DROP = 2'd2   // response pending but belongs to a flushed path
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]           instr;
    logic [FETCH_XLEN-1:0] pc;
    logic                  fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered instruction queue. The head entry is read straight
// out of storage, so a push at cycle N is visible at the head at N+1.
//   clk, rst_n   clock / async active-low reset
//   clr          synchronous empty (redirect)
//   push, wdata  write port; ignored when full unless a pop happens too
//   pop          read-advance; ignored when empty
//   rdata, valid head entry and its validity
//   count        number of valid entries (0..DEPTH)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 1 + 32 + FETCH_XLEN,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  assign do_push = push & ((count != FULL) | do_pop);
  assign rdata   = mem[rptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a small queue.
// Optional feature macro: FETCH_MISALIGN_EN -- a PC with [1:0]!=0 in IDLE
// pushes a fault entry instead of issuing a memory request.
//   clk, rst_n                      clock / async active-low reset
//   pc_i, pc_stall_o                PC in; hold PC register while stall high
//   flush_i                         redirect, drops queue and in-flight fetch
//   imem_req_o/addr_o/gnt_i         request channel
//   imem_rvalid_i/rdata_i           response channel
//   instr_valid_o/ready_i           decode handshake
//   instr_o/pc_o/fault_o            queue head
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN   = FETCH_XLEN,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_stall_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_fault_o
);

  localparam int EW = 32 + XLEN + 1;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QD = CW'(QDEPTH);

  fetch_state_e    state, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   q_count;
  logic            room, misalign, fire, resp, mis_push, push;
  logic [EW-1:0]   wdata, head;
  logic            head_fault;

`ifdef FETCH_MISALIGN_EN
  assign misalign = (pc_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign room = (q_count < QD);

  // rst_n gates the combinational outputs so they read idle during reset,
  // not only after the first clock.
  assign imem_req_o  = rst_n & (state == ST_IDLE) & room & ~flush_i & ~misalign;
  assign imem_addr_o = pc_i;
  assign fire        = imem_req_o & imem_gnt_i;
  assign pc_stall_o  = ~(fire | (flush_i & rst_n));

  assign resp     = (state == ST_WAIT) & imem_rvalid_i;
  assign mis_push = (state == ST_IDLE) & room & misalign;
  assign push     = ~flush_i & (resp | mis_push);
  assign wdata    = resp ? {imem_rdata_i, pc_q, 1'b0} : {32'h0, pc_i, 1'b1};

  // A response landing in the same cycle as a flush closes the transaction,
  // so WAIT goes straight to IDLE; likewise DROP leaves as soon as the stale
  // response arrives, even if another flush is present.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (fire) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid_i)  state_d = ST_IDLE;
        else if (flush_i)   state_d = ST_DROP;
      end
      ST_DROP: if (imem_rvalid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_d;
      if (fire) pc_q <= pc_i;
    end
  end

  fetch_fifo #(.W(EW), .DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush_i),
    .push  (push),
    .wdata (wdata),
    .pop   (instr_ready_i),
    .rdata (head),
    .valid (instr_valid_o),
    .count (q_count)
  );

  assign {instr_o, instr_pc_o, head_fault} = head;

`ifdef FETCH_MISALIGN_EN
  assign instr_fault_o = instr_valid_o & head_fault;
`else
  logic unused_fault;
  assign unused_fault  = head_fault;
  assign instr_fault_o = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter QDEPTH, default 2, instruction queue entries; must be a power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc_i  input  XLEN  current PC from the PC register.
REQ-006 SHALL have port pc_stall_o  output  1  holds the PC register when high.
REQ-007 SHALL have port flush_i  input  1  redirect; discards queued and in-flight fetches.
REQ-008 SHALL have port imem_req_o  output  1  instruction-memory request.
REQ-009 SHALL have port imem_addr_o  output  XLEN  request address.
REQ-010 SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid_i  input  1  read data valid.
REQ-012 SHALL have port imem_rdata_i  input  32  read data.
REQ-013 SHALL have ports instr_valid_o/instr_ready_i  output/input  1 each  decode handshake.
REQ-014 SHALL have ports instr_o  output  32, instr_pc_o  output  XLEN, instr_fault_o  output  1.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT (one request outstanding) and DROP (outstanding response to discard).
REQ-016 SHALL drive imem_req_o=1 only in IDLE, when queue count < QDEPTH and flush_i=0; imem_addr_o=pc_i.
REQ-017 SHALL transition IDLE->WAIT on imem_req_o&imem_gnt_i, latching pc_i as the entry PC.
REQ-018 SHALL hold imem_req_o and imem_addr_o stable until granted, unless flush_i asserts.
REQ-019 SHALL drive pc_stall_o=0 only in a cycle with imem_req_o&imem_gnt_i or flush_i=1; otherwise 1.
REQ-020 SHALL, in WAIT with imem_rvalid_i=1, push {imem_rdata_i, latched PC, fault=0} and return to IDLE; a new request SHALL be allowed the following cycle.
REQ-021 SHALL present the queue head registered: rvalid at cycle N gives instr_valid_o=1 at N+1.
REQ-022 SHALL pop on instr_valid_o&instr_ready_i; instr_o/instr_pc_o SHALL hold while valid and not ready.
REQ-023 SHALL allow push and pop in the same cycle, count unchanged; wrap read/write pointers modulo QDEPTH.
REQ-024 SHALL, on flush_i, empty the queue next cycle (instr_valid_o=0), move WAIT->DROP, and issue no request that cycle.
REQ-025 SHALL, in DROP, discard the next imem_rvalid_i and go to IDLE; flush_i in DROP SHALL keep DROP.
REQ-026 SHALL never exceed one outstanding request; imem_rvalid_i in IDLE SHALL be ignored.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, count 0, pointers 0, imem_req_o=0, instr_valid_o=0, instr_fault_o=0, pc_stall_o=1.
REQ-028 SHALL abandon any outstanding request on reset; the first rvalid after reset release in IDLE is ignored.

Configuration
REQ-029 SHALL, with FETCH_MISALIGN_EN defined, treat pc_i[1:0]!=0 in IDLE as fault: no memory request, push {32'h0, pc_i, fault=1} directly, pc_stall_o=1.
REQ-030 SHALL, without FETCH_MISALIGN_EN, ignore pc_i[1:0] and tie instr_fault_o to 0.

Structure
REQ-031 SHALL place fetch state enum, queue entry struct {instr, pc, fault} and default XLEN in package fetch_pkg.
REQ-032 SHALL implement the queue as sub-module fetch_fifo (parameterised width/depth, count output).

Verification
REQ-033 Reset then pc_i=0x100, gnt same cycle, rvalid 2 cycles later with 0x00500093 -> instr_valid_o one cycle after rvalid, instr_o=0x00500093, instr_pc_o=0x100.
REQ-034 instr_ready_i=0, QDEPTH=2, two fetches complete -> imem_req_o=0, pc_stall_o=1 until one pop.
REQ-035 gnt delayed 3 cycles -> imem_addr_o stable, pc_stall_o=1 for those cycles, 0 on grant cycle only.
REQ-036 flush_i in WAIT, then rvalid 0xDEADBEEF -> data not queued, instr_valid_o=0, next request uses new pc_i.
REQ-037 Simultaneous push and pop with count=1 -> count stays 1, order preserved across pointer wrap.
REQ-038 FETCH_MISALIGN_EN, pc_i=0x102 -> no imem_req_o, instr_fault_o=1, instr_pc_o=0x102.
